alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver.sv | 212 +++++++++++++++++++++
 tb/tb_alu_driver.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
//
// Queues ALU requests in a small FIFO and plays them one at a time onto an
// external tri-state ALU. Each transaction presents the opcode and operands
// with the ALU output disabled for SETTLE cycles, enables the ALU for exactly
// one cycle while its result is captured, then offers the result on a
// valid/ready response channel until it is taken.
//
// A DIV with a zero divisor keeps the full transaction timing but never
// enables the ALU; it answers 16'hFFFF with rsp_err set.
//
// Parameters
//   FIFO_DEPTH  request FIFO entries, power of two in 2..16
//   SETTLE      cycles the operands are held with alu_oe low, 1..7
//
// Ports
//   clock, reset                 single clock; asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready = FIFO not full)
//   req_cmd, req_a, req_b        opcode and operands of the offered request
//   alu_command, alu_a, alu_b    opcode and operands driven to the ALU
//   alu_oe, alu_y                ALU output enable and its tri-state result
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_cmd, rsp_err   result, opcode it belongs to, divide-by-zero
//   busy                         FIFO non-empty or a transaction in progress
//   req_count                    FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module alu_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,

  output logic [3:0]  alu_command,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_oe,
  input  logic [15:0] alu_y,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_err,

  output logic        busy,
  output logic [4:0]  req_count
);

  localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_COUNT = 5'(FIFO_DEPTH);
  localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [3:0]  OP_DIV      = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [4:0]        count;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        settle_cnt;
  logic              div_zero;

  // Readiness comes from the occupancy at the start of the cycle only, so a
  // pop in the same cycle never opens a slot for a push into a full FIFO.
  assign req_ready = (count != DEPTH_COUNT);
  assign push      = req_valid && req_ready;
  assign req_count = count;
  assign busy      = (count != 5'd0) || (state != S_IDLE);

  // NOTE: the storage array has no reset; occupancy and pointers are reset,
  // and nothing reads an entry that has not been written since.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{cmd: req_cmd, a: req_a, b: req_b};
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      // Depth is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  // The operand registers double as the ALU drive, so the divide-by-zero test
  // looks at what is currently presented to the ALU.
  assign div_zero = (alu_command == OP_DIV) && (alu_b == 8'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so that no
  // path through the case statement leaves a latch behind.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    alu_oe    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != 5'd0) begin
          pop       = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // A zero divisor keeps the slot but never lets the ALU drive the bus.
        alu_oe    = !div_zero;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Settle counter: restarts on every load, counts the cycles spent in DRIVE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_cnt <= 3'd0;
    end else if (pop) begin
      settle_cnt <= 3'd0;
    end else if (state == S_DRIVE) begin
      settle_cnt <= settle_cnt + 3'd1;
    end
  end

  // Operand registers change only when a request is popped (IDLE -> DRIVE)
  // and otherwise keep driving the last transaction's values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_command <= 4'd0;
      alu_a       <= 8'd0;
      alu_b       <= 8'd0;
    end else if (pop) begin
      alu_command <= mem[rd_ptr].cmd;
      alu_a       <= mem[rd_ptr].a;
      alu_b       <= mem[rd_ptr].b;
    end
  end

  // Response registers are loaded at the end of SAMPLE and then hold through
  // RESP, whatever rsp_ready does, until the next transaction samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_data <= 16'd0;
      rsp_cmd  <= 4'd0;
      rsp_err  <= 1'b0;
    end else if (state == S_SAMPLE) begin
      rsp_data <= div_zero ? 16'hFFFF : alu_y;
      rsp_cmd  <= alu_command;
      rsp_err  <= div_zero;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_driver
//
// Bench for alu_driver. A transaction-level model (FIFO contents as a queue,
// the single in-flight request with its age in cycles) predicts every output
// each cycle; a second queue of accepted requests pins response order. A
// SETTLE=3 instance covers the longer settle window with literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_driver;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  logic        clock;
  logic        reset;

  // Main instance (SETTLE = 1)
  logic        req_valid, req_ready;
  logic [3:0]  req_cmd;
  logic [7:0]  req_a, req_b;
  logic [3:0]  alu_command;
  logic [7:0]  alu_a, alu_b;
  logic        alu_oe;
  logic [15:0] alu_y;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic        rsp_err, busy;
  logic [4:0]  req_count;

  // SETTLE = 3 instance
  logic        req_valid3, req_ready3;
  logic [3:0]  req_cmd3;
  logic [7:0]  req_a3, req_b3;
  logic [3:0]  alu_command3;
  logic [7:0]  alu_a3, alu_b3;
  logic        alu_oe3;
  logic [15:0] alu_y3;
  logic        rsp_valid3, rsp_ready3;
  logic [15:0] rsp_data3;
  logic [3:0]  rsp_cmd3;
  logic        rsp_err3, busy3;
  logic [4:0]  req_count3;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // External ALU: drives its result only while enabled, junk otherwise.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (c)
      4'h0:    return wa + wb;
      4'h1:    return wa - wb;
      4'h2:    return wa & wb;
      4'h3:    return wa | wb;
      4'h4:    return wa * wb;
      4'h5:    return (b == 8'd0) ? 16'h0000 : wa / wb;
      4'h6:    return wa << b[3:0];
      4'h7:    return wa >> b[3:0];
      4'hF:    return wa;
      default: return {c, 4'h0, a ^ b};
    endcase
  endfunction

  function automatic bit is_div0(input req_t r);
    return (r.cmd == 4'h5) && (r.b == 8'd0);
  endfunction

  function automatic logic [15:0] expect_data(input req_t r);
    return is_div0(r) ? 16'hFFFF : alu_fn(r.cmd, r.a, r.b);
  endfunction

  assign alu_y  = alu_oe  ? alu_fn(alu_command,  alu_a,  alu_b)  : 16'hDEAD;
  assign alu_y3 = alu_oe3 ? alu_fn(alu_command3, alu_a3, alu_b3) : 16'hDEAD;

  alu_driver #(.FIFO_DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oe(alu_oe), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cmd(rsp_cmd), .rsp_err(rsp_err),
    .busy(busy), .req_count(req_count)
  );

  alu_driver #(.FIFO_DEPTH(4), .SETTLE(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_cmd(req_cmd3),
    .req_a(req_a3), .req_b(req_b3),
    .alu_command(alu_command3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_oe(alu_oe3), .alu_y(alu_y3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_cmd(rsp_cmd3), .rsp_err(rsp_err3),
    .busy(busy3), .req_count(req_count3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. A request waits in fq until the driver is free; it then
  // spends SETTLE cycles being driven (age 0..SETTLE-1), one cycle sampled
  // (age SETTLE), and is offered as a response until taken (age > SETTLE).
  // ---------------------------------------------------------------------------
  req_t        fq[$];
  req_t        acc_q[$];
  bit          active;
  int          age;
  req_t        cur;
  logic [19:0] m_alu;
  logic [20:0] m_rsp;
  int          n_acc   = 0;
  int          dut_rsp = 0;

  always @(posedge clock or posedge reset) begin
    bit take;
    if (reset) begin
      fq.delete();
      acc_q.delete();
      active = 0;
      age    = 0;
      m_alu  = '0;
      m_rsp  = '0;
    end else begin
      take = req_valid && (fq.size() < DEPTH);
      if (active) begin
        if (age == SETTLE) begin
          m_rsp = {is_div0(cur), cur.cmd, expect_data(cur)};
          age++;
        end else if (age < SETTLE) begin
          age++;
        end else if (rsp_ready) begin
          active = 0;
          void'(acc_q.pop_front());
        end
      end else if (fq.size() > 0) begin
        cur    = fq.pop_front();
        active = 1;
        age    = 0;
        m_alu  = cur;
      end
      if (take) begin
        fq.push_back('{cmd: req_cmd, a: req_a, b: req_b});
        acc_q.push_back('{cmd: req_cmd, a: req_a, b: req_b});
        n_acc++;
      end
    end
  end

  // Per-cycle comparison, on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("req_ready", req_ready, fq.size() < DEPTH);
      check("req_count", req_count, fq.size());
      check("busy", busy, (fq.size() > 0) || active);
      check("alu_oe", alu_oe, active && (age == SETTLE) && !is_div0(cur));
      check("rsp_valid", rsp_valid, active && (age > SETTLE));
      check("alu_drive", {alu_command, alu_a, alu_b}, m_alu);
      check("rsp_regs", {rsp_err, rsp_cmd, rsp_data}, m_rsp);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        dut_rsp++;
        if (acc_q.size() == 0)
          check("rsp_unrequested", rsp_valid, 1'b0);
        else
          check("rsp_order", {rsp_err, rsp_cmd, rsp_data},
                {is_div0(acc_q[0]), acc_q[0].cmd, expect_data(acc_q[0])});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok        = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 300; i++) begin
      bit rdy;
      rdy = req_ready;
      tick();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    check("send_accepted", ok, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("rsp_seen", seen, 1'b1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        idle = 1;
        break;
      end
      tick();
    end
    check("idle_reached", idle, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:1] oe_h, v_h;
    logic [5:1] oe3_h, v3_h;
    int         oe_cnt;
    int         base_acc, base_rsp;
    bit         any_valid;

    reset      = 1'b1;
    req_valid  = 1'b0; req_cmd  = 4'd0; req_a  = 8'd0; req_b  = 8'd0;
    rsp_ready  = 1'b1;
    req_valid3 = 1'b0; req_cmd3 = 4'd0; req_a3 = 8'd0; req_b3 = 8'd0;
    rsp_ready3 = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_req_count", req_count, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_oe", alu_oe, 1'b0);
    check("rst_alu_drive", {alu_command, alu_a, alu_b}, 20'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_regs", {rsp_err, rsp_cmd, rsp_data}, 21'h0);
    reset = 1'b0;
    tick();

    // SETTLE=3 instance: SHL 0x81 by 1, accepted at edge N
    req_valid3 = 1'b1; req_cmd3 = 4'h6; req_a3 = 8'h81; req_b3 = 8'h01;
    tick();
    req_valid3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      oe3_h[k] = alu_oe3;
      v3_h[k]  = rsp_valid3;
    end
    check("s3_oe_pattern", oe3_h, 5'b01000);
    check("s3_valid_pattern", v3_h, 5'b10000);
    check("s3_rsp_data", rsp_data3, 16'h0102);
    check("s3_rsp_err", rsp_err3, 1'b0);

    // ADD 0x0F + 0x01: one enable pulse, response from edge N+3
    send(4'h0, 8'h0F, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      tick();
      oe_h[k] = alu_oe;
      v_h[k]  = rsp_valid;
    end
    check("add_oe_pattern", oe_h, 3'b010);
    check("add_valid_pattern", v_h, 3'b100);
    check("add_rsp", {rsp_err, rsp_cmd, rsp_data}, {1'b0, 4'h0, 16'h0010});
    tick();

    // DIV by zero, then a real DIV
    send(4'h5, 8'h20, 8'h00);
    oe_cnt = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (alu_oe) oe_cnt++;
      tick();
    end
    check("div0_oe_count", oe_cnt, 0);
    check("div0_rsp", {rsp_valid, rsp_err, rsp_cmd, rsp_data}, {1'b1, 1'b1, 4'h5, 16'hFFFF});
    tick();
    send(4'h5, 8'h20, 8'h04);
    wait_rsp();
    check("div_rsp", {rsp_err, rsp_cmd, rsp_data}, {1'b0, 4'h5, 16'h0008});
    tick();

    // MUL 0xFF * 0xFF held for ten cycles under backpressure
    rsp_ready = 1'b0;
    wait_idle();
    send(4'h4, 8'hFF, 8'hFF);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      check("hold_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 16'hFE01});
      check("hold_alu", {alu_command, alu_a, alu_b}, 20'h4FFFF);
      tick();
    end
    rsp_ready = 1'b1;
    tick();

    // Backpressure fill: the head request leaves the FIFO for the operand
    // registers, so five are taken, four sit in the FIFO and the sixth waits.
    rsp_ready = 1'b0;
    wait_idle();
    base_rsp = dut_rsp;
    for (int i = 0; i < 5; i++) send(4'h0, 8'(8'h10 + i), 8'h01);
    req_valid = 1'b1; req_cmd = 4'h1; req_a = 8'h50; req_b = 8'h05;
    tick();
    tick();
    check("full_count", req_count, 5'd4);
    check("full_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    send(4'h1, 8'h50, 8'h05);
    wait_idle();
    check("full_rsp_count", dut_rsp - base_rsp, 6);

    // Reset during SAMPLE with three requests queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'h3, 8'(8'h30 + i), 8'h0C);
    wait_rsp();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !alu_oe; i++) tick();
    check("pre_reset_oe", alu_oe, 1'b1);
    check("pre_reset_count", req_count, 5'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_oe", alu_oe, 1'b0);
    check("rst_mid_valid", rsp_valid, 1'b0);
    check("rst_mid_count", req_count, 5'd0);
    tick();
    tick();
    reset = 1'b0;
    any_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) any_valid = 1;
      tick();
    end
    check("post_reset_no_rsp", any_valid, 1'b0);

    // Randomized traffic against the model
    base_acc = n_acc;
    base_rsp = dut_rsp;
    for (int i = 0; i < 2500; i++) begin
      req_valid = ($urandom_range(0, 99) < 50);
      req_cmd   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) req_cmd = 4'h5;
      req_a     = 8'($urandom);
      req_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("random_all_answered", dut_rsp - base_rsp, n_acc - base_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
